// File: rtl/genesis_multipad_scanner_if.sv
// Purpose : bundles the DB9 pad lines and the decoded joystick outputs of the multipad scanner.
// Latency : none; wires only.
// Backpressure: none; the master (scanner) drives select/decoded data unconditionally.
// Signals : iVSYNC, iGENPAD (pad side -> scanner); oGENPAD_SELECT, oGENPAD_TYPE,
//           oGENPAD_DECODED, oUPDATE (scanner -> pads/core). Modports: master = scanner, slave = environment.
interface genesis_multipad_scanner_if #(
    parameter int NUM_PADS = 2
) ();
    logic                     iVSYNC;
    logic [6*NUM_PADS-1:0]    iGENPAD;
    logic [NUM_PADS-1:0]      oGENPAD_SELECT;
    logic [2*NUM_PADS-1:0]    oGENPAD_TYPE;
    logic [12*NUM_PADS-1:0]   oGENPAD_DECODED;
    logic                     oUPDATE;

    modport master (
        input  iVSYNC,
        input  iGENPAD,
        output oGENPAD_SELECT,
        output oGENPAD_TYPE,
        output oGENPAD_DECODED,
        output oUPDATE
    );

    modport slave (
        output iVSYNC,
        output iGENPAD,
        input  oGENPAD_SELECT,
        input  oGENPAD_TYPE,
        input  oGENPAD_DECODED,
        input  oUPDATE
    );
endinterface

// File: rtl/genesis_multipad_scanner.sv
// Purpose : scans 1..4 Genesis/Master System pads with one shared 8-phase select burst, decodes type + 12 buttons.
// Latency : after an IDLE_TICKS gap, a burst of 8*HALF_PERIOD+1 cycles; outputs change with a one-cycle oUPDATE.
// Backpressure: none; pads are sampled and outputs driven unconditionally.
// Ports   : iCLK, iN_RESET (synchronous, active low); pads (master modport of genesis_multipad_scanner_if):
//           iVSYNC, iGENPAD in; oGENPAD_SELECT, oGENPAD_TYPE, oGENPAD_DECODED, oUPDATE out.
// Build   : define GENPAD_FILTER_EN to commit each type/button bit only when it agrees with the previous burst.
module genesis_multipad_scanner #(
    parameter int NUM_PADS    = 2,
    parameter int HALF_PERIOD = 500,
    parameter int SETTLE      = 48,
    parameter int IDLE_TICKS  = 100000,
    parameter int SYNC_MODE   = 0
) (
    input  logic                       iCLK,
    input  logic                       iN_RESET,
    genesis_multipad_scanner_if.master pads
);
    localparam int TW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int GW = (IDLE_TICKS > 0) ? $clog2(IDLE_TICKS + 1) : 1;
    localparam logic [TW-1:0] T_LAST   = TW'(HALF_PERIOD - 1);
    localparam logic [TW-1:0] T_SAMPLE = TW'(SETTLE);
    localparam logic [GW-1:0] GAP_END  = GW'(IDLE_TICKS);

    localparam logic [1:0] TYPE_MS    = 2'd0;
    localparam logic [1:0] TYPE_3BTN  = 2'd1;
    localparam logic [1:0] TYPE_6BTN  = 2'd2;
    localparam logic [1:0] TYPE_ERROR = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        PHASE,
        COMMIT
    } state_t;

    state_t                  state;
    logic [2:0]              phase;
    logic [TW-1:0]           tick;
    logic [GW-1:0]           gap;
    logic                    pending;
    logic                    vsync_d;

    // Shadows keep only the bits the decode looks at:
    // l0 = {Start,A,Left,Right}, h0 = full 6 bits, l2/h3 = low nibble.
    logic [4*NUM_PADS-1:0]   sh_l0;
    logic [6*NUM_PADS-1:0]   sh_h0;
    logic [4*NUM_PADS-1:0]   sh_l2;
    logic [4*NUM_PADS-1:0]   sh_h3;

    logic [NUM_PADS-1:0]     select_q;
    logic [2*NUM_PADS-1:0]   type_q;
    logic [12*NUM_PADS-1:0]  btn_q;
    logic                    update_q;

    logic [2*NUM_PADS-1:0]   dec_type;
    logic [12*NUM_PADS-1:0]  dec_btn;
    logic [2*NUM_PADS-1:0]   commit_type;
    logic [12*NUM_PADS-1:0]  commit_btn;

    // l0_lr = L0 {Left,Right}; zero there means a 3/6-button pad is answering.
    function automatic logic [1:0] pad_type(input logic [1:0] l0_lr,
                                            input logic [3:0] l2,
                                            input logic [3:0] h3);
        logic [1:0] ty;
        if (l0_lr != 2'b00) begin
            ty = TYPE_MS;
        end else if (l2 == 4'b0000) begin
            // All four extended bits low in H3 cannot come from a real 6-button pad.
            ty = (h3 == 4'b0000) ? TYPE_ERROR : TYPE_6BTN;
        end else begin
            ty = TYPE_3BTN;
        end
        return ty;
    endfunction

    // Output word {Z,Y,X,M,S,C,B,A,U,D,L,R}, active high.
    function automatic logic [11:0] pad_btn(input logic [1:0] ty,
                                            input logic [1:0] sa,
                                            input logic [5:0] h0,
                                            input logic [3:0] h3);
        logic [11:0] b;
        b      = '0;
        b[6:5] = ~h0[5:4];
        b[3:0] = ~h0[3:0];
        if (ty != TYPE_MS) begin
            b[7] = ~sa[1];
            b[4] = ~sa[0];
        end
        if (ty == TYPE_6BTN) begin
            b[11:8] = ~h3;
        end
        return b;
    endfunction

    always_comb begin
        dec_type = '0;
        dec_btn  = '0;
        for (int n = 0; n < NUM_PADS; n++) begin
            dec_type[2*n +: 2]  = pad_type(sh_l0[4*n +: 2], sh_l2[4*n +: 4], sh_h3[4*n +: 4]);
            dec_btn[12*n +: 12] = pad_btn(pad_type(sh_l0[4*n +: 2], sh_l2[4*n +: 4], sh_h3[4*n +: 4]),
                                          sh_l0[4*n+2 +: 2], sh_h0[6*n +: 6], sh_h3[4*n +: 4]);
        end
    end

`ifdef GENPAD_FILTER_EN
    logic [2*NUM_PADS-1:0]  prev_type;
    logic [12*NUM_PADS-1:0] prev_btn;
    logic [2*NUM_PADS-1:0]  type_same;
    logic [12*NUM_PADS-1:0] btn_same;

    // A bit only moves when two consecutive bursts agree on it.
    assign type_same   = ~(dec_type ^ prev_type);
    assign btn_same    = ~(dec_btn ^ prev_btn);
    assign commit_type = (dec_type & type_same) | (type_q & ~type_same);
    assign commit_btn  = (dec_btn & btn_same) | (btn_q & ~btn_same);
`else
    assign commit_type = dec_type;
    assign commit_btn  = dec_btn;
`endif

    always_ff @(posedge iCLK) begin
        if (!iN_RESET) begin
            state    <= IDLE;
            phase    <= '0;
            tick     <= '0;
            gap      <= '0;
            pending  <= 1'b0;
            // Seeded high so a VSYNC already high at reset release is not taken as an edge.
            vsync_d  <= 1'b1;
            sh_l0    <= '1;
            sh_h0    <= '1;
            sh_l2    <= '1;
            sh_h3    <= '1;
            select_q <= '1;
            type_q   <= '0;
            btn_q    <= '0;
            update_q <= 1'b0;
`ifdef GENPAD_FILTER_EN
            prev_type <= '0;
            prev_btn  <= '0;
`endif
        end else begin
            update_q <= 1'b0;
            vsync_d  <= pads.iVSYNC;

            case (state)
                IDLE: begin
                    select_q <= '1;
                    if (gap == GAP_END) begin
                        if ((SYNC_MODE == 0) || pending) begin
                            state    <= PHASE;
                            phase    <= '0;
                            tick     <= '0;
                            select_q <= '0;
                            pending  <= 1'b0;
                        end
                    end else begin
                        gap <= gap + 1'b1;
                    end
                end

                PHASE: begin
                    if (tick == T_SAMPLE) begin
                        for (int n = 0; n < NUM_PADS; n++) begin
                            case (phase)
                                3'd0: sh_l0[4*n +: 4] <= {pads.iGENPAD[6*n+4 +: 2], pads.iGENPAD[6*n +: 2]};
                                3'd1: sh_h0[6*n +: 6] <= pads.iGENPAD[6*n +: 6];
                                3'd4: sh_l2[4*n +: 4] <= pads.iGENPAD[6*n +: 4];
                                3'd7: sh_h3[4*n +: 4] <= pads.iGENPAD[6*n +: 4];
                                default: ;
                            endcase
                        end
                    end
                    if (tick == T_LAST) begin
                        tick <= '0;
                        if (phase == 3'd7) begin
                            state    <= COMMIT;
                            select_q <= '1;
                        end else begin
                            phase    <= phase + 3'd1;
                            // Next phase index is phase+1, whose LSB is the inverse of the current one.
                            select_q <= {NUM_PADS{~phase[0]}};
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end

                COMMIT: begin
                    state    <= IDLE;
                    gap      <= '0;
                    select_q <= '1;
                    type_q   <= commit_type;
                    btn_q    <= commit_btn;
                    update_q <= 1'b1;
`ifdef GENPAD_FILTER_EN
                    prev_type <= dec_type;
                    prev_btn  <= dec_btn;
`endif
                end

                default: begin
                    state    <= IDLE;
                    gap      <= '0;
                    select_q <= '1;
                end
            endcase

            // Placed after the FSM so an edge in the same cycle a burst starts still queues a request.
            if ((SYNC_MODE != 0) && pads.iVSYNC && !vsync_d) begin
                pending <= 1'b1;
            end
        end
    end

    assign pads.oGENPAD_SELECT  = select_q;
    assign pads.oGENPAD_TYPE    = type_q;
    assign pads.oGENPAD_DECODED = btn_q;
    assign pads.oUPDATE         = update_q;
endmodule

// File: tb/tb_genesis_multipad_scanner.sv
// Purpose : directed self-checking bench for genesis_multipad_scanner (free-running and VSYNC-triggered instances).
// Latency : n/a.
// Backpressure: n/a; a behavioural 6-button/3-button pad model answers the select line.
module tb_genesis_multipad_scanner;
    localparam int NP = 2;
    localparam int HP = 20;
    localparam int ST = 4;
    localparam int IT = 200;
`ifdef GENPAD_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif
    localparam int NB = FILT ? 2 : 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic vsync = 1'b0;
    int   cyc   = 0;
    int   errs  = 0;
    int   checks = 0;

    genesis_multipad_scanner_if #(.NUM_PADS(NP)) pif ();
    genesis_multipad_scanner_if #(.NUM_PADS(NP)) sif ();

    genesis_multipad_scanner #(
        .NUM_PADS(NP), .HALF_PERIOD(HP), .SETTLE(ST), .IDLE_TICKS(IT), .SYNC_MODE(0)
    ) dut (
        .iCLK(clk), .iN_RESET(rst_n), .pads(pif)
    );

    genesis_multipad_scanner #(
        .NUM_PADS(NP), .HALF_PERIOD(HP), .SETTLE(ST), .IDLE_TICKS(IT), .SYNC_MODE(1)
    ) dut_sync (
        .iCLK(clk), .iN_RESET(rst_n), .pads(sif)
    );

    // Pad configuration: mode 0 = disconnected, 1 = 3-button, 2 = 6-button.
    // Buttons in output order {Z,Y,X,M,S,C,B,A,U,D,L,R}, 1 = pressed.
    int          pmode [NP] = '{0, 0};
    logic [11:0] pbtn  [NP] = '{12'h000, 12'h000};

    // Low-phase counter of the 6-button pad; cleared by a long select-high gap.
    int   k        = 0;
    int   hi_cnt   = 0;
    logic sel_prev = 1'b1;
    always @(negedge clk) begin
        if (pif.oGENPAD_SELECT[0]) begin
            hi_cnt <= hi_cnt + 1;
            if (hi_cnt > 3 * HP) k <= 0;
        end else begin
            hi_cnt <= 0;
            if (sel_prev) k <= k + 1;
        end
        sel_prev <= pif.oGENPAD_SELECT[0];
    end

    function automatic logic [5:0] pad_out(input int mode, input logic [11:0] b, input logic sel, input int kk);
        logic [5:0] v;  // 1 = line pulled low
        if (mode == 0) return 6'h3F;
        if (sel) begin
            if (mode == 2 && kk == 4) v = {b[6], b[5], b[11], b[10], b[9], b[8]};
            else                      v = {b[6], b[5], b[3], b[2], b[1], b[0]};
        end else begin
            if (mode == 2 && kk == 3)      v = {b[7], b[4], 4'b1111};
            else if (mode == 2 && kk == 4) v = {b[7], b[4], 4'b0000};
            else                           v = {b[7], b[4], b[3], b[2], 2'b11};
        end
        return ~v;
    endfunction

    assign pif.iGENPAD = {pad_out(pmode[1], pbtn[1], pif.oGENPAD_SELECT[1], k),
                          pad_out(pmode[0], pbtn[0], pif.oGENPAD_SELECT[0], k)};
    assign pif.iVSYNC  = 1'b0;
    assign sif.iGENPAD = '1;
    assign sif.iVSYNC  = vsync;

    int s_upd_q [$];
    always @(negedge clk) begin
        if (sif.oUPDATE === 1'b1) s_upd_q.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc = cyc + 1;
        @(negedge clk);
    endtask

    task automatic wait_upd(input int n, input string tag);
        int seen;
        int c;
        seen = 0;
        c    = 0;
        while (seen < n && c < 400 * n + 400) begin
            step();
            c++;
            if (pif.oUPDATE === 1'b1) seen++;
        end
        chk(tag, seen, n);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_low, last_tog, toggles, upd_cnt, upd_at, c, s_start;
        bit spacing_ok, same_ok, sync_idle_ok;
        logic prev;

        // ---- 1: reset state and free-running burst timing ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_select", pif.oGENPAD_SELECT, 2'b11);
        chk("rst_type", pif.oGENPAD_TYPE, 4'h0);
        chk("rst_decoded", pif.oGENPAD_DECODED, 24'h0);
        chk("rst_update", pif.oUPDATE, 1'b0);
        rst_n = 1'b1;
        cyc   = 0;
        first_low = -1; last_tog = -1; toggles = 0; upd_cnt = 0; upd_at = -1;
        spacing_ok = 1'b1; same_ok = 1'b1; sync_idle_ok = 1'b1; prev = 1'b1;
        for (int i = 0; i < 370; i++) begin
            step();
            if (pif.oGENPAD_SELECT[0] !== pif.oGENPAD_SELECT[1]) same_ok = 1'b0;
            if (sif.oGENPAD_SELECT !== 2'b11) sync_idle_ok = 1'b0;
            if (pif.oGENPAD_SELECT[0] !== prev) begin
                if (toggles == 0) first_low = cyc;
                else if (cyc != last_tog + HP) spacing_ok = 1'b0;
                last_tog = cyc;
                toggles++;
            end
            prev = pif.oGENPAD_SELECT[0];
            if (pif.oUPDATE === 1'b1) begin
                upd_cnt++;
                upd_at = cyc;
            end
        end
        chk("t1_first_low", first_low, 201);
        chk("t1_toggles", toggles, 8);
        chk("t1_spacing", spacing_ok, 1'b1);
        chk("t1_select_same", same_ok, 1'b1);
        chk("t1_update_count", upd_cnt, 1);
        chk("t1_update_cycle", upd_at, 362);
        chk("t1_disconnected_type", pif.oGENPAD_TYPE, 4'h0);
        chk("t4_sync_idle_no_vsync", sync_idle_ok, 1'b1);

        // ---- 2: 3-button pad on pad0, Start + Up ----
        pmode[0] = 1; pbtn[0] = 12'h088;
        pmode[1] = 0; pbtn[1] = 12'h000;
        wait_upd(NB, "t2_update");
        chk("t2_type", pif.oGENPAD_TYPE, 4'b0001);
        chk("t2_decoded", pif.oGENPAD_DECODED, 24'h000088);

        // ---- 3: 6-button pad on pad1 (Z + Mode), pad0 disconnected ----
        pmode[0] = 0; pbtn[0] = 12'h000;
        pmode[1] = 2; pbtn[1] = 12'h900;
        wait_upd(NB, "t3_update");
        chk("t3_type", pif.oGENPAD_TYPE, 4'b1000);
        chk("t3_decoded", pif.oGENPAD_DECODED, 24'h900000);

        // ---- 3b: 6-button with Z,Y,X,M held reads as error; 3-button C,B,Left ----
        pmode[0] = 2; pbtn[0] = 12'hF11;
        pmode[1] = 1; pbtn[1] = 12'h062;
        wait_upd(NB, "t3b_update");
        chk("t3b_type", pif.oGENPAD_TYPE, 4'b0111);
        chk("t3b_decoded", pif.oGENPAD_DECODED, 24'h062011);

        // ---- 4: VSYNC-triggered instance ----
        s_upd_q.delete();
        vsync = 1'b1;
        step();
        vsync = 1'b0;
        c = 0;
        while (sif.oGENPAD_SELECT !== 2'b00 && c < 10) begin
            step();
            c++;
        end
        chk("t4_start_latency", c, 1);
        s_start = cyc;
        repeat (30) step();
        vsync = 1'b1; step(); vsync = 1'b0;
        repeat (20) step();
        vsync = 1'b1; step(); vsync = 1'b0;
        repeat (1000) step();
        chk("t4_burst_count", s_upd_q.size(), 2);
        chk("t4_first_update", (s_upd_q.size() > 0) ? s_upd_q[0] - s_start : -1, 161);
        chk("t4_second_gap", (s_upd_q.size() > 1) ? s_upd_q[1] - s_upd_q[0] : -1, 362);

        // ---- 5: reset during phase 5 ----
        wait_upd(1, "t5_sync_update");
        c = 0;
        while (pif.oGENPAD_SELECT !== 2'b00 && c < 400) begin
            step();
            c++;
        end
        chk("t5_gap_to_burst", c, 201);
        repeat (5 * HP + 5) step();
        chk("t5_phase5_select", pif.oGENPAD_SELECT, 2'b11);
        chk("t5_pre_reset_decoded", pif.oGENPAD_DECODED, 24'h062011);
        rst_n = 1'b0;
        step();
        chk("t5_select", pif.oGENPAD_SELECT, 2'b11);
        chk("t5_type", pif.oGENPAD_TYPE, 4'h0);
        chk("t5_decoded", pif.oGENPAD_DECODED, 24'h0);
        chk("t5_update", pif.oUPDATE, 1'b0);
        rst_n = 1'b1;
        cyc = 0; upd_cnt = 0; first_low = -1;
        for (int i = 0; i < 210; i++) begin
            step();
            if (pif.oUPDATE === 1'b1) upd_cnt++;
            if (first_low < 0 && pif.oGENPAD_SELECT === 2'b00) first_low = cyc;
        end
        chk("t5_no_commit", upd_cnt, 0);
        chk("t5_restart_low", first_low, 201);

        // ---- 6: history filter (or direct commit without it) ----
        wait_upd(1, "t6_first_update");
        chk("t6_first_type", pif.oGENPAD_TYPE, FILT ? 4'b0000 : 4'b0111);
        chk("t6_first_decoded", pif.oGENPAD_DECODED, FILT ? 24'h0 : 24'h062011);
        pmode[0] = 1; pbtn[0] = 12'h000;
        pmode[1] = 0; pbtn[1] = 12'h000;
        wait_upd(2, "t6_baseline_update");
        chk("t6_baseline_type", pif.oGENPAD_TYPE, 4'b0001);
        chk("t6_baseline_decoded", pif.oGENPAD_DECODED, 24'h0);
        pbtn[0] = 12'h010;
        wait_upd(1, "t6_once_update");
        chk("t6_a_one_burst", pif.oGENPAD_DECODED[4], FILT ? 1'b0 : 1'b1);
        pbtn[0] = 12'h000;
        wait_upd(1, "t6_release_update");
        chk("t6_a_released", pif.oGENPAD_DECODED[4], 1'b0);
        pbtn[0] = 12'h010;
        wait_upd(1, "t6_hold1_update");
        chk("t6_a_hold_first", pif.oGENPAD_DECODED[4], FILT ? 1'b0 : 1'b1);
        wait_upd(1, "t6_hold2_update");
        chk("t6_a_hold_second", pif.oGENPAD_DECODED[4], 1'b1);
        chk("t6_final_decoded", pif.oGENPAD_DECODED, 24'h000010);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
